// File: rtl/pix_uart_tx.sv
// pix_uart_tx - pixel return path to the host over a single UART TX line.
// Processed 12-bit pixels arrive on a valid strobe with no backpressure.
// They are queued in a small FIFO and sent as two 8N1 bytes, high nibble first.
// Build option: define YUV_DECODE_EN to decode {Y,Ur,Vr} to {R,G,B} before the FIFO.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle high; pops the next pixel when the FIFO has one
// S_START | start bit (0) of the current byte
// S_DATA  | data bits of the current byte, LSB first
// S_STOP  | stop bit (1); chains into byte1 or ends the pixel frame
module pix_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16,
   parameter int ADDR_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] pix_in,
   input  logic        pix_valid,
   output logic        tx,
   output logic        busy,
   output logic        fifo_empty,
   output logic        fifo_full,
   output logic        overflow,
   output logic        pix_sent
);

   localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TMR_W-1:0]  C_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0]   C_DEPTH  = (ADDR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Input decode
   // ------------------------------------------------------------------
   logic [11:0] w_pix_wr;

`ifdef YUV_DECODE_EN
   logic [3:0] w_y;
   logic [3:0] w_ur;
   logic [3:0] w_vr;
   logic [4:0] w_uv_sum;
   logic [3:0] w_g;
   logic [3:0] w_r;
   logic [3:0] w_b;

   assign w_y      = pix_in[11:8];
   assign w_ur     = pix_in[7:4];
   assign w_vr     = pix_in[3:0];
   // Sum is kept at 5 bits so the carry survives the shift.
   assign w_uv_sum = {1'b0, w_ur} + {1'b0, w_vr};
   assign w_g      = w_y - {1'b0, w_uv_sum[4:2]};
   assign w_r      = w_ur + w_g;
   assign w_b      = w_vr + w_g;
   assign w_pix_wr = {w_r, w_g, w_b};
`else
   assign w_pix_wr = pix_in;
`endif

   // ------------------------------------------------------------------
   // Pixel FIFO
   // ------------------------------------------------------------------
   logic [11:0]       r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overflow;
   logic              w_full;
   logic              w_empty;
   logic              w_wr_en;
   logic              w_pop;

   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   // A full FIFO drops the write even if a pop frees a slot on the same edge.
   assign w_wr_en = pix_valid & ~w_full;

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= w_pix_wr;
      end
   end

   // Pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (pix_valid && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Serializer FSM
   // ------------------------------------------------------------------
   state_t            r_state;
   state_t            w_state_nxt;
   logic [11:0]       r_hold;
   logic [11:0]       w_hold_nxt;
   logic              r_byte_sel;
   logic              w_byte_sel_nxt;
   logic [2:0]        r_bit_idx;
   logic [2:0]        w_bit_idx_nxt;
   logic [TMR_W-1:0]  r_timer;
   logic [TMR_W-1:0]  w_timer_nxt;
   logic              r_tx;
   logic              w_tx_nxt;
   logic              r_pix_sent;
   logic              w_pix_sent_nxt;
   logic [7:0]        w_byte;
   logic              w_tmr_done;

   // byte0 carries the top nibble zero-extended, byte1 the low eight bits.
   assign w_byte     = r_byte_sel ? r_hold[7:0] : {4'h0, r_hold[11:8]};
   assign w_tmr_done = (r_timer == '0);

   // State and datapath registers; tx idles high out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_hold     <= '0;
         r_byte_sel <= 1'b0;
         r_bit_idx  <= '0;
         r_timer    <= '0;
         r_tx       <= 1'b1;
         r_pix_sent <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold     <= w_hold_nxt;
         r_byte_sel <= w_byte_sel_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_timer    <= w_timer_nxt;
         r_tx       <= w_tx_nxt;
         r_pix_sent <= w_pix_sent_nxt;
      end
   end

   // Next-state logic: the bit timer reloads at every bit boundary and
   // counts down; terminal count at zero ends the current bit.
   always_comb begin
      w_state_nxt    = r_state;
      w_hold_nxt     = r_hold;
      w_byte_sel_nxt = r_byte_sel;
      w_bit_idx_nxt  = r_bit_idx;
      w_timer_nxt    = r_timer;
      w_tx_nxt       = r_tx;
      w_pix_sent_nxt = 1'b0;
      w_pop          = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (!w_empty) begin
               w_pop          = 1'b1;
               w_hold_nxt     = r_mem[r_rd_ptr];
               w_byte_sel_nxt = 1'b0;
               w_tx_nxt       = 1'b0;
               w_timer_nxt    = C_RELOAD;
               w_state_nxt    = S_START;
            end
         end

         S_START: begin
            if (w_tmr_done) begin
               w_bit_idx_nxt = 3'd0;
               w_tx_nxt      = w_byte[0];
               w_timer_nxt   = C_RELOAD;
               w_state_nxt   = S_DATA;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end

         S_DATA: begin
            if (w_tmr_done) begin
               w_timer_nxt = C_RELOAD;
               if (r_bit_idx == 3'd7) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_tx_nxt      = w_byte[r_bit_idx + 3'd1];
               end
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end

         S_STOP: begin
            if (w_tmr_done) begin
               if (!r_byte_sel) begin
                  // Second byte of the pixel follows with no idle gap.
                  w_byte_sel_nxt = 1'b1;
                  w_tx_nxt       = 1'b0;
                  w_timer_nxt    = C_RELOAD;
                  w_state_nxt    = S_START;
               end else begin
                  w_pix_sent_nxt = 1'b1;
                  w_state_nxt    = S_IDLE;
               end
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end

         default: begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // tx is forced high by reset without waiting for the register to settle.
   assign tx         = r_tx | rst;
   assign busy       = (r_state != S_IDLE);
   assign fifo_empty = w_empty;
   assign fifo_full  = w_full;
   assign overflow   = r_overflow;
   assign pix_sent   = r_pix_sent;

endmodule

// File: tb/tb_pix_uart_tx.sv
// tb_pix_uart_tx - directed bench for pix_uart_tx.
// A fast instance (4 clocks/bit) covers data, framing, FIFO and reset;
// a second instance at 868 clocks/bit covers the real bit period.
module tb_pix_uart_tx;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst;
   logic [11:0] pix_in;
   logic pix_valid;
   logic tx, busy, fifo_empty, fifo_full, overflow, pix_sent;

   logic [11:0] pix_in_s;
   logic pix_valid_s;
   logic tx_s, busy_s, fifo_empty_s, fifo_full_s, overflow_s, pix_sent_s;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   int         rx_t[$];
   int         rx_bad = 0;
   int         sent_n = 0;
   int         sent_t = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   pix_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .ADDR_W(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .tx         (tx),
      .busy       (busy),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .pix_sent   (pix_sent)
   );

   pix_uart_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(16), .ADDR_W(4)) u_dut_slow (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in_s),
      .pix_valid  (pix_valid_s),
      .tx         (tx_s),
      .busy       (busy_s),
      .fifo_empty (fifo_empty_s),
      .fifo_full  (fifo_full_s),
      .overflow   (overflow_s),
      .pix_sent   (pix_sent_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected FIFO contents for a given input word.
   function automatic logic [11:0] f_dec(input logic [11:0] p);
`ifdef YUV_DECODE_EN
      logic [3:0] y, u, v, g;
      logic [4:0] s;
      y = p[11:8];
      u = p[7:4];
      v = p[3:0];
      s = {1'b0, u} + {1'b0, v};
      g = y - {1'b0, s[4:2]};
      return {u + g, g, v + g};
`else
      return p;
`endif
   endfunction

   function automatic logic [11:0] burst_val(input int i);
      logic [11:0] v;
      v = 12'h0C3;
      for (int k = 0; k < i; k++) v = v + 12'h1A7;
      return v;
   endfunction

   // UART receiver on the fast tx line; samples mid-bit at falling clock edges.
   initial begin
      int cnt;
      int t0;
      logic on;
      logic [7:0] sh;
      logic [2:0] bi;
      cnt = 0;
      t0 = 0;
      on = 1'b0;
      sh = '0;
      forever begin
         @(negedge clk);
         if (pix_sent) begin
            sent_n++;
            sent_t = cyc;
         end
         if (rst) begin
            on = 1'b0;
         end else if (!on) begin
            if (!tx) begin
               on = 1'b1;
               cnt = 0;
               t0 = cyc;
            end
         end else begin
            cnt++;
            if (cnt == 2) begin
               if (tx) rx_bad++;
            end else if (cnt >= 6 && cnt <= 34 && (cnt % 4) == 2) begin
               bi = 3'((cnt - 6) / 4);
               sh[bi] = tx;
            end else if (cnt == 38) begin
               if (!tx) rx_bad++;
               rx_q.push_back(sh);
               rx_t.push_back(t0);
               on = 1'b0;
            end
         end
      end
   end

   task automatic send_pix(input logic [11:0] p);
      @(negedge clk);
      pix_in = p;
      pix_valid = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int i;
      i = 0;
      while (rx_q.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin
      int e0, s0, lowc, highc, i, t_first;
      logic [11:0] d;

      rst = 1'b1;
      pix_in = '0;
      pix_valid = 1'b0;
      pix_in_s = '0;
      pix_valid_s = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_full", fifo_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_sent", pix_sent, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single pixel: byte values, latency, no gap within a pixel, pix_sent timing
      clear_rx();
      s0 = sent_n;
`ifdef YUV_DECODE_EN
      send_pix({4'd8, 4'd2, 4'd2});
      e0 = cyc;
      wait_bytes(2, 300);
      repeat (10) @(negedge clk);
      check("yuv1_nbytes", rx_q.size(), 2);
      check("yuv1_b0", rx_q[0], 8'h09);
      check("yuv1_b1", rx_q[1], 8'h79);
      check("yuv1_latency", rx_t[0] - e0, 1);
      clear_rx();
      send_pix({4'd0, 4'd0, 4'd4});
      wait_bytes(2, 300);
      repeat (10) @(negedge clk);
      check("yuv2_nbytes", rx_q.size(), 2);
      check("yuv2_b0", rx_q[0], 8'h0F);
      check("yuv2_b1", rx_q[1], 8'hF3);
      check("yuv_sent", sent_n - s0, 2);
`else
      send_pix(12'hA5C);
      e0 = cyc;
      wait_bytes(2, 300);
      repeat (10) @(negedge clk);
      check("a5c_nbytes", rx_q.size(), 2);
      check("a5c_b0", rx_q[0], 8'h0A);
      check("a5c_b1", rx_q[1], 8'h5C);
      check("a5c_latency", rx_t[0] - e0, 1);
      check("a5c_b1_start", rx_t[1] - rx_t[0], 2 * 10 * CPB / 2);
      check("a5c_sent_cnt", sent_n - s0, 1);
      check("a5c_sent_time", sent_t - rx_t[0], 80);
`endif
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);

      // Two pixels back to back: one idle cycle between pixels only
      clear_rx();
      s0 = sent_n;
      @(negedge clk);
      pix_in = 12'h123;
      pix_valid = 1'b1;
      @(negedge clk);
      pix_in = 12'hFFF;
      @(negedge clk);
      pix_valid = 1'b0;
      wait_bytes(4, 400);
      repeat (10) @(negedge clk);
      check("two_nbytes", rx_q.size(), 4);
      d = f_dec(12'h123);
      check("two_b0", rx_q[0], {4'h0, d[11:8]});
      check("two_b1", rx_q[1], d[7:0]);
      d = f_dec(12'hFFF);
      check("two_b2", rx_q[2], {4'h0, d[11:8]});
      check("two_b3", rx_q[3], d[7:0]);
      check("two_gap01", rx_t[1] - rx_t[0], 40);
      check("two_gap12", rx_t[2] - rx_t[1], 41);
      check("two_gap23", rx_t[3] - rx_t[2], 40);
      check("two_sent", sent_n - s0, 2);
      check("two_empty", fifo_empty, 1);

      // Burst of 18: 17 accepted, last one dropped
      clear_rx();
      s0 = sent_n;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (k == 17) begin
            check("burst_full_e16", fifo_full, 1);
            check("burst_ovf_e16", overflow, 0);
         end
         pix_in = burst_val(k);
         pix_valid = 1'b1;
      end
      @(negedge clk);
      pix_valid = 1'b0;
      check("burst_full", fifo_full, 1);
      check("burst_ovf", overflow, 1);
      wait_bytes(34, 17 * 81 + 200);
      repeat (200) @(negedge clk);
      check("burst_nbytes", rx_q.size(), 34);
      for (int k = 0; k < 17; k++) begin
         d = f_dec(burst_val(k));
         check($sformatf("burst_b0_%0d", k), rx_q[2 * k], {4'h0, d[11:8]});
         check($sformatf("burst_b1_%0d", k), rx_q[2 * k + 1], d[7:0]);
      end
      check("burst_sent", sent_n - s0, 17);
      check("burst_ovf_sticky", overflow, 1);

      // Reset in the middle of byte0 data, with a second pixel queued
      clear_rx();
      @(negedge clk);
      pix_in = 12'h555;
      pix_valid = 1'b1;
      @(negedge clk);
      pix_in = 12'hAAA;
      @(negedge clk);
      pix_valid = 1'b0;
      repeat (12) @(negedge clk);
      check("rstmid_busy_before", busy, 1);
      s0 = sent_n;
      rst = 1'b1;
      #1;
      check("rstmid_tx", tx, 1);
      check("rstmid_busy", busy, 0);
      check("rstmid_empty", fifo_empty, 1);
      check("rstmid_ovf", overflow, 0);
      repeat (3) @(negedge clk);
      check("rstmid_tx_hold", tx, 1);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("rstmid_nbytes", rx_q.size(), 0);
      check("rstmid_sent", sent_n - s0, 0);
      check("rstmid_tx_after", tx, 1);
      check("rstmid_busy_after", busy, 0);

      // Real bit rate on the slow instance
      @(negedge clk);
      pix_in_s = 12'h100;
      pix_valid_s = 1'b1;
      @(negedge clk);
      pix_valid_s = 1'b0;
      t_first = cyc;
      i = 0;
      while (tx_s && i < 100) begin
         @(negedge clk);
         i++;
      end
      lowc = 0;
      while (!tx_s && lowc < 2000) begin
         @(negedge clk);
         lowc++;
      end
      highc = 0;
      while (tx_s && highc < 2000) begin
         @(negedge clk);
         highc++;
      end
      check("slow_start_bit", lowc, 868);
      check("slow_bit0", highc, 868);
      while (cyc < t_first + 20000) @(negedge clk);
      pix_in_s = 12'h200;
      pix_valid_s = 1'b1;
      @(negedge clk);
      pix_valid_s = 1'b0;
      check("slow_ovf_send", overflow_s, 0);
      repeat (5) @(negedge clk);
      i = 0;
      while (busy_s && i < 20000) begin
         @(negedge clk);
         i++;
      end
      check("slow_done", busy_s, 0);
      check("slow_ovf_end", overflow_s, 0);
      check("slow_tx_idle", tx_s, 1);

      check("rx_framing", rx_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pix_uart_tx.md
Name: pix_uart_tx

Overview:
Return path from the convolution engine to the host PC (FPGA -> MATLAB).
- Accepts processed 12-bit pixels on a valid strobe with no backpressure.
- Buffers them in a small FIFO and serializes each pixel as two 8N1 UART bytes on a single TX line.
- Acts as the transmit counterpart to the UART receive path that feeds pixels into the window/convolution array.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2
FIFO_DEPTH, 16, pixel FIFO entries; power of two
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
pix_in  input  12  pixel {R[11:8],G[7:4],B[3:0]}, or {Y,Ur,Vr} when YUV_DECODE_EN is defined
pix_valid  input  1  pix_in is valid this cycle; single-cycle strobe, no ready returned
tx  output  1  UART serial out, idle high
busy  output  1  high while a pixel frame (two bytes) is in flight
fifo_empty  output  1  FIFO count == 0
fifo_full  output  1  FIFO count == FIFO_DEPTH
overflow  output  1  sticky; set when a valid pixel is dropped
pix_sent  output  1  one-cycle pulse at the end of the second stop bit

Behaviour:
- Only clk and rst are used; all state is in one clock domain.
- Reset values (asynchronous): tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, pix_sent=0, FIFO pointers and count=0, FSM=IDLE.
- rst asserted mid-frame aborts immediately. tx returns high combinationally with reset and FIFO contents are discarded. No partial frame resumes after release.
- FIFO write:
  - On a clk edge with pix_valid=1 and count<FIFO_DEPTH, pix_in (or its decoded value) is written.
  - On a clk edge with pix_valid=1 and count==FIFO_DEPTH, the pixel is dropped and overflow is set. overflow clears only on rst.
  - Write and pop on the same edge: count is unchanged. A full FIFO still drops the write even if a pop occurs on that edge.
- Byte packing, per pixel: byte0={4'h0,p[11:8]}, byte1={p[7:4],p[3:0]}. byte0 is sent first; each byte is sent LSB first.
- Frame format: start bit 0, 8 data bits, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles, counted by a bit-timer reloaded at each bit boundary.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If FIFO not empty: pop into a 12-bit holding register, byte_sel<=0, tx<=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: drive the selected byte's bit[idx]. After CLKS_PER_BIT cycles, idx++. After idx 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_sel==0: byte_sel<=1 and enter START with no idle gap. Else: pulse pix_sent and go to IDLE.
- busy is 1 in START/DATA/STOP.
- Latency: pix_valid sampled at edge E0 into an empty FIFO with FSM in IDLE gives tx low after edge E1.
- Timing per pixel: 20*CLKS_PER_BIT cycles plus exactly one IDLE cycle between consecutive pixels when the FIFO is non-empty.
- The holding register is stable for the whole frame; FIFO writes during transmission do not affect the frame in flight.

Optional Feature:
YUV_DECODE_EN
- Defined: input is treated as {Y,Ur,Vr} and decoded before the FIFO write. All arithmetic is 4-bit unsigned, wrapping mod 16:
  - G = Y - ((Ur+Vr)>>2), where Ur+Vr is a 5-bit sum
  - R = Ur + G
  - B = Vr + G
  - The decoder is combinational in front of the FIFO; latency is unchanged.
- Undefined: pix_in is stored unchanged.

Test Plan:
- Use CLKS_PER_BIT=4 unless stated.
- Passthrough, single pix_in=12'hA5C:
  - tx: start, byte0 0x0A (bits 0,1,0,1,0,0,0,0), stop.
  - Then immediately start, byte1 0x5C (bits 0,0,1,1,1,0,1,0), stop.
  - Every bit lasts 4 cycles. pix_sent pulses once, 80 cycles after the tx falling edge.
- Burst of 18 consecutive pix_valid cycles into an idle block, depth 16:
  - First pixel is popped at E1, so 17 are accepted.
  - The 18th sets fifo_full=1 and overflow=1.
  - Exactly 17 frames are emitted, each carrying the expected value.
- Reset during DATA of byte0:
  - tx=1, busy=0, fifo_empty=1, overflow=0 while rst is high.
  - After release, tx stays high with no pix_sent.
- Two pixels 12'h123 and 12'hFFF: bytes 0x01,0x23,0x0F,0xFF.
  - No idle cycle between stop and start within a pixel.
  - Exactly one tx-high IDLE cycle between the two pixels.
- YUV_DECODE_EN defined:
  - pix_in {8,2,2} gives bytes 0x09,0x79.
  - pix_in {0,0,4} gives G=F, R=F, B=3, bytes 0x0F,0xF3 (checks the wrap).
- CLKS_PER_BIT=868: measure the bit period on tx as 868 cycles; overflow stays 0 for pixels spaced 20000 cycles apart.
